dma_priority_arbiter: RTL and testbench
=======================================

DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 RESET_N  input  1  asynchronous active-low reset.
REQ-004 DREQ  input  4  external DMA request per channel, asynchronous to CLK.
REQ-005 dreqSense  input  1  0 = DREQ active-high, 1 = DREQ active-low.
REQ-006 dackSense  input  1  0 = DACK active-low, 1 = DACK active-high.
REQ-007 rotatePri  input  1  0 = fixed priority, 1 = rotating priority.
REQ-008 ctrlDisable  input  1  1 = no new arbitration is started.
REQ-009 maskReg  input  4  1 = the channel's hardware DREQ is masked.
REQ-010 swReq  input  4  software request per channel; the mask does not apply to it.
REQ-011 HLDA  input  1  hold acknowledge from the CPU.
REQ-012 EOP_N  input  1  sampled end-of-process, active-low.
REQ-013 svcDone  input  1  one-cycle pulse from timing control marking a completed single transfer.
REQ-014 VALID_DREG  output  4  one-hot granted channel, consumed by timing control.
REQ-015 grantCh  output  2  encoded granted channel.
REQ-016 HRQ  output  1  hold request to the CPU.
REQ-017 DACK  output  4  channel acknowledge; polarity set by dackSense.
REQ-018 swReqClr  output  4  one-cycle pulse that clears the granted channel's software request.

Function
REQ-019 DREQ SHALL pass through a 2-flop synchronizer before use, giving 2 cycles of latency from pin to arbitration.
REQ-020 The effective request SHALL be req[i] = ((dreqSync[i] XOR dreqSense) AND NOT maskReg[i]) OR swReq[i].
REQ-021 The FSM SHALL have the states IDLE, WAIT_HLDA, SERVICE and RELEASE.
REQ-022 In IDLE, when ctrlDisable=0 and any req is set, the FSM SHALL latch the winner, assert HRQ and VALID_DREG one-hot, set grantCh, and go to WAIT_HLDA, all in the next cycle.
REQ-023 Fixed priority SHALL be ch0 highest through ch3 lowest.
REQ-024 In rotating priority the highest channel SHALL be (lastCh+1) mod 4, wrapping 3->0.
REQ-025 lastCh SHALL update to the winner on leaving SERVICE, and only when rotatePri=1.
REQ-026 The winner SHALL stay frozen from grant until return to IDLE; higher-priority requests arriving meanwhile SHALL NOT preempt it.
REQ-027 In WAIT_HLDA, if req[winner] drops before HLDA=1, the FSM SHALL go to IDLE and clear HRQ and VALID_DREG in the next cycle.
REQ-028 In WAIT_HLDA with HLDA=1, the FSM SHALL go to SERVICE and assert DACK[winner] in the next cycle.
REQ-029 In SERVICE, svcDone=1 or EOP_N=0 SHALL cause a transition to RELEASE that deasserts DACK, HRQ and VALID_DREG in the next cycle.
REQ-030 On that SERVICE exit, if swReq[winner]=1, swReqClr[winner] SHALL pulse for exactly 1 cycle.
REQ-031 If svcDone and EOP_N=0 occur in the same cycle, they SHALL be handled as a single exit.
REQ-032 In RELEASE the FSM SHALL wait for HLDA=0, then go to IDLE; re-arbitration is possible no earlier than the following cycle.
REQ-033 ctrlDisable=1 SHALL block only the IDLE->WAIT_HLDA transition; a grant already in progress SHALL complete normally.
REQ-034 Each DACK[i] SHALL equal dackSense when acknowledged and NOT dackSense otherwise, combinationally from state and dackSense.
REQ-035 EOP_N=0 in IDLE or WAIT_HLDA SHALL be ignored.

Reset
REQ-036 While RESET_N=0 the block SHALL asynchronously force: state=IDLE, lastCh=3, synchronizer=0, HRQ=0, VALID_DREG=0000, grantCh=00 and swReqClr=0000.
REQ-037 While RESET_N=0, DACK SHALL read inactive, i.e. 1111 with dackSense=0.
REQ-038 Reset asserted mid-SERVICE SHALL drop DACK and HRQ immediately.
REQ-039 After RESET_N is released, the first arbitration SHALL occur no earlier than 2 cycles later.

Verification
REQ-040 Fixed priority: DREQ=1010, mask=0000, rotatePri=0 -> VALID_DREG=0010 and HRQ=1 3 cycles after DREQ; HLDA=1 -> DACK=1101 in the next cycle.
REQ-041 Rotation: rotatePri=1, ch1 serviced, then DREQ=1111 -> next grant is ch2, then ch3, then ch0.
REQ-042 Mask/software request: maskReg=1111, DREQ=1111, swReq=0100 -> grant ch2; on svcDone, swReqClr=0100 for 1 cycle.
REQ-043 Drop before acknowledge: grant ch0, DREQ[0] falls before HLDA -> HRQ=0 and VALID_DREG=0000 with no DACK.
REQ-044 End of process and reset: EOP_N=0 in SERVICE -> RELEASE, HRQ=0, then IDLE after HLDA=0.
REQ-045 Reset mid-SERVICE: RESET_N=0 -> DACK=1111 and HRQ=0 asynchronously.
REQ-046 Disable: ctrlDisable=1 with DREQ pending -> HRQ stays 0.

Source files
------------

// File: rtl/dma_priority_arbiter_if.sv
// Bus bundle between the DMA priority arbiter and its environment.
// The slave side is the arbiter; the master side drives requests and
// configuration and observes grants and acknowledges.
interface dma_priority_arbiter_if;
  logic [3:0] DREQ;
  logic       dreqSense;
  logic       dackSense;
  logic       rotatePri;
  logic       ctrlDisable;
  logic [3:0] maskReg;
  logic [3:0] swReq;
  logic       HLDA;
  logic       EOP_N;
  logic       svcDone;
  logic [3:0] VALID_DREG;
  logic [1:0] grantCh;
  logic       HRQ;
  logic [3:0] DACK;
  logic [3:0] swReqClr;

  modport slave (
    input  DREQ, dreqSense, dackSense, rotatePri, ctrlDisable, maskReg,
           swReq, HLDA, EOP_N, svcDone,
    output VALID_DREG, grantCh, HRQ, DACK, swReqClr
  );

  modport master (
    output DREQ, dreqSense, dackSense, rotatePri, ctrlDisable, maskReg,
           swReq, HLDA, EOP_N, svcDone,
    input  VALID_DREG, grantCh, HRQ, DACK, swReqClr
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA priority arbiter with hold-request handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no grant; arbitrate among effective requests
// WAIT_HLDA | winner latched, HRQ raised, waiting for the CPU to yield
// SERVICE   | bus owned, DACK asserted for the winner
// RELEASE   | service finished, waiting for HLDA to drop
//
// The winner is frozen from grant until the return to IDLE, so late
// higher-priority requests never preempt a grant in progress.
module dma_priority_arbiter (
  input  logic                         CLK,
  input  logic                         RESET_N,
  dma_priority_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HLDA = 2'd1,
    SERVICE   = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] dreq_meta, dreq_sync;
  logic [3:0] req;
  logic [1:0] winner, winner_nxt;
  logic [1:0] last_ch, last_ch_nxt;
  logic [1:0] pri_base, pick, idx;
  logic       found;
  logic [3:0] sw_req_clr, sw_req_clr_nxt;
  logic [3:0] winner_onehot, ack;
  logic       hold_active;

  // Two-flop synchronizer for the asynchronous DREQ pins
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dreq_meta <= '0;
      dreq_sync <= '0;
    end else begin
      dreq_meta <= bus.DREQ;
      dreq_sync <= dreq_meta;
    end
  end

  // Software requests bypass the hardware mask on purpose
  assign req = ((dreq_sync ^ {4{bus.dreqSense}}) & ~bus.maskReg) | bus.swReq;

  // Rotation starts one past the last serviced channel; fixed mode starts at ch0
  assign pri_base = bus.rotatePri ? (last_ch + 2'd1) : 2'd0;

  // Scan channels in priority order and take the first one requesting
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = pri_base + 2'(k);
      if (req[idx] && !found) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // State, winner, rotation pointer and clear-pulse registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      winner     <= '0;
      last_ch    <= 2'd3;
      sw_req_clr <= '0;
    end else begin
      state      <= state_nxt;
      winner     <= winner_nxt;
      last_ch    <= last_ch_nxt;
      sw_req_clr <= sw_req_clr_nxt;
    end
  end

  // Next-state logic; svcDone and EOP_N together still form one exit
  always_comb begin
    state_nxt      = state;
    winner_nxt     = winner;
    last_ch_nxt    = last_ch;
    sw_req_clr_nxt = '0;
    case (state)
      IDLE: begin
        if (!bus.ctrlDisable && found) begin
          winner_nxt = pick;
          state_nxt  = WAIT_HLDA;
        end
      end
      WAIT_HLDA: begin
        if (bus.HLDA) begin
          state_nxt = SERVICE;
        end else if (!req[winner]) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (bus.svcDone || !bus.EOP_N) begin
          state_nxt = RELEASE;
          if (bus.rotatePri) begin
            last_ch_nxt = winner;
          end
          if (bus.swReq[winner]) begin
            sw_req_clr_nxt = 4'b0001 << winner;
          end
        end
      end
      RELEASE: begin
        if (!bus.HLDA) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign winner_onehot = 4'b0001 << winner;
  assign hold_active   = (state == WAIT_HLDA) || (state == SERVICE);
  assign ack           = (state == SERVICE) ? winner_onehot : 4'b0000;

  assign bus.HRQ        = hold_active;
  assign bus.VALID_DREG = hold_active ? winner_onehot : 4'b0000;
  assign bus.grantCh    = winner;
  assign bus.DACK       = bus.dackSense ? ack : ~ack;
  assign bus.swReqClr   = sw_req_clr;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter with a cycle-level reference model.
module tb_dma_priority_arbiter;

  logic CLK = 1'b0;
  logic RESET_N;
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam int P_IDLE = 0, P_HOLD = 1, P_OWN = 2, P_DONE = 3;

  int         m_phase, m_win, m_last, m_grant;
  logic [3:0] m_clr, m_s1, m_s2;

  dma_priority_arbiter_if bus ();

  dma_priority_arbiter dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Channel whose distance from the top-priority channel is smallest
  function automatic int model_pick(input logic [3:0] r, input int top);
    int best = 0;
    int best_rank = 4;
    for (int ch = 0; ch < 4; ch++) begin
      if (r[ch] && ((ch - top + 4) % 4) < best_rank) begin
        best      = ch;
        best_rank = (ch - top + 4) % 4;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_win = 0; m_last = 3; m_grant = 0;
    m_clr = '0; m_s1 = '0; m_s2 = '0;
  endtask

  // Advance the model by one rising edge using the inputs held across it
  task automatic model_step();
    logic [3:0] r;
    logic [3:0] clr;
    if (!RESET_N) begin
      model_reset();
      return;
    end
    r   = ((m_s2 ^ {4{bus.dreqSense}}) & ~bus.maskReg) | bus.swReq;
    clr = '0;
    if (m_phase == P_IDLE) begin
      if (!bus.ctrlDisable && r != 4'b0000) begin
        m_win   = model_pick(r, bus.rotatePri ? (m_last + 1) % 4 : 0);
        m_grant = m_win;
        m_phase = P_HOLD;
      end
    end else if (m_phase == P_HOLD) begin
      if (bus.HLDA) m_phase = P_OWN;
      else if (!r[m_win]) m_phase = P_IDLE;
    end else if (m_phase == P_OWN) begin
      if (bus.svcDone || !bus.EOP_N) begin
        if (bus.swReq[m_win]) clr[m_win] = 1'b1;
        if (bus.rotatePri) m_last = m_win;
        m_phase = P_DONE;
      end
    end else begin
      if (!bus.HLDA) m_phase = P_IDLE;
    end
    m_clr = clr;
    m_s2  = m_s1;
    m_s1  = bus.DREQ;
  endtask

  task automatic compare_model();
    logic       held;
    logic [3:0] exp_dack;
    held = (m_phase == P_HOLD) || (m_phase == P_OWN);
    for (int i = 0; i < 4; i++)
      exp_dack[i] = (m_phase == P_OWN && m_win == i) ? bus.dackSense : ~bus.dackSense;
    check("m_hrq",   {3'b000, bus.HRQ}, {3'b000, held});
    check("m_valid", bus.VALID_DREG, held ? (4'b0001 << m_win) : 4'b0000);
    check("m_grant", {2'b00, bus.grantCh}, 4'(m_grant));
    check("m_dack",  bus.DACK, exp_dack);
    check("m_clr",   bus.swReqClr, m_clr);
  endtask

  // One cycle: edge, model update, compare, then return at the falling edge
  task automatic tick();
    @(posedge CLK);
    model_step();
    #2;
    compare_model();
    @(negedge CLK);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Grant already in WAIT_HLDA: acknowledge, complete, release, one idle cycle
  task automatic serve();
    bus.HLDA = 1'b1;
    tick();
    bus.svcDone = 1'b1;
    tick();
    bus.svcDone = 1'b0;
    bus.HLDA    = 1'b0;
    ticks(2);
  endtask

  logic [3:0] rot_exp [3];

  initial begin
    rot_exp[0] = 4'b0100; rot_exp[1] = 4'b1000; rot_exp[2] = 4'b0001;
    model_reset();
    RESET_N         = 1'b0;
    bus.DREQ        = 4'b0000;
    bus.dreqSense   = 1'b0;
    bus.dackSense   = 1'b0;
    bus.rotatePri   = 1'b0;
    bus.ctrlDisable = 1'b0;
    bus.maskReg     = 4'b0000;
    bus.swReq       = 4'b0000;
    bus.HLDA        = 1'b0;
    bus.EOP_N       = 1'b1;
    bus.svcDone     = 1'b0;
    #1;
    check("rst_hrq",   {3'b000, bus.HRQ}, 4'b0000);
    check("rst_valid", bus.VALID_DREG, 4'b0000);
    check("rst_grant", {2'b00, bus.grantCh}, 4'b0000);
    check("rst_dack",  bus.DACK, 4'b1111);
    check("rst_clr",   bus.swReqClr, 4'b0000);
    ticks(2);
    RESET_N = 1'b1;
    ticks(2);

    // Fixed priority: ch1 beats ch3, three cycles after DREQ
    bus.DREQ = 4'b1010;
    ticks(2);
    check("fix_early", bus.VALID_DREG, 4'b0000);
    tick();
    check("fix_valid", bus.VALID_DREG, 4'b0010);
    check("fix_hrq",   {3'b000, bus.HRQ}, 4'b0001);
    bus.HLDA = 1'b1;
    bus.DREQ = 4'b0000;
    tick();
    check("fix_dack", bus.DACK, 4'b1101);
    bus.svcDone = 1'b1;
    tick();
    bus.svcDone = 1'b0;
    check("fix_rel_hrq",  {3'b000, bus.HRQ}, 4'b0000);
    check("fix_rel_dack", bus.DACK, 4'b1111);
    bus.HLDA = 1'b0;
    ticks(3);

    // Inverted senses and EOP exit
    bus.maskReg = 4'b1111; bus.DREQ = 4'b1111; bus.dreqSense = 1'b1;
    ticks(3);
    bus.maskReg = 4'b0000;
    bus.DREQ    = 4'b1110;
    ticks(3);
    check("inv_valid", bus.VALID_DREG, 4'b0001);
    bus.dackSense = 1'b1; bus.HLDA = 1'b1; bus.DREQ = 4'b1111;
    tick();
    check("inv_dack", bus.DACK, 4'b0001);
    bus.EOP_N = 1'b0;
    tick();
    bus.EOP_N = 1'b1;
    check("eop_hrq",  {3'b000, bus.HRQ}, 4'b0000);
    check("eop_dack", bus.DACK, 4'b0000);
    tick();
    check("eop_hold", {3'b000, bus.HRQ}, 4'b0000);
    bus.HLDA = 1'b0;
    ticks(2);
    bus.maskReg = 4'b1111; bus.DREQ = 4'b0000;
    bus.dreqSense = 1'b0; bus.dackSense = 1'b0;
    ticks(3);
    bus.maskReg = 4'b0000;

    // Rotation after servicing ch1
    bus.rotatePri = 1'b1;
    bus.DREQ = 4'b0010;
    ticks(3);
    check("rot_first", bus.VALID_DREG, 4'b0010);
    bus.DREQ = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      serve();
      check("rot_next", bus.VALID_DREG, rot_exp[k]);
    end
    bus.DREQ = 4'b0000;
    serve();
    bus.rotatePri = 1'b0;

    // Software request through a full mask
    bus.maskReg = 4'b1111; bus.DREQ = 4'b1111; bus.swReq = 4'b0100;
    tick();
    check("sw_valid", bus.VALID_DREG, 4'b0100);
    bus.HLDA = 1'b1;
    tick();
    check("sw_dack", bus.DACK, 4'b1011);
    bus.svcDone = 1'b1;
    tick();
    bus.svcDone = 1'b0;
    check("sw_clr", bus.swReqClr, 4'b0100);
    bus.swReq = 4'b0000;
    tick();
    check("sw_clr_end", bus.swReqClr, 4'b0000);
    bus.HLDA = 1'b0; bus.DREQ = 4'b0000;
    ticks(3);
    bus.maskReg = 4'b0000;

    // Request withdrawn before HLDA
    bus.DREQ = 4'b0001;
    ticks(3);
    check("drop_valid", bus.VALID_DREG, 4'b0001);
    bus.DREQ = 4'b0000;
    ticks(3);
    check("drop_hrq",   {3'b000, bus.HRQ}, 4'b0000);
    check("drop_valid0", bus.VALID_DREG, 4'b0000);
    check("drop_dack",  bus.DACK, 4'b1111);

    // Disable blocks new grants; EOP in IDLE is ignored
    bus.ctrlDisable = 1'b1; bus.DREQ = 4'b1000; bus.EOP_N = 1'b0;
    ticks(5);
    check("dis_hrq", {3'b000, bus.HRQ}, 4'b0000);
    bus.ctrlDisable = 1'b0; bus.EOP_N = 1'b1;
    tick();
    check("dis_valid", bus.VALID_DREG, 4'b1000);
    bus.ctrlDisable = 1'b1; bus.DREQ = 4'b0000;
    serve();
    bus.ctrlDisable = 1'b0;

    // Asynchronous reset in SERVICE, restart latency, combined exit
    bus.DREQ = 4'b0100;
    ticks(3);
    bus.HLDA = 1'b1;
    tick();
    check("pre_rst_dack", bus.DACK, 4'b1011);
    RESET_N = 1'b0;
    #1;
    check("arst_dack",  bus.DACK, 4'b1111);
    check("arst_hrq",   {3'b000, bus.HRQ}, 4'b0000);
    check("arst_valid", bus.VALID_DREG, 4'b0000);
    ticks(2);
    bus.HLDA = 1'b0;
    RESET_N = 1'b1;
    ticks(2);
    check("post_rst_idle", {3'b000, bus.HRQ}, 4'b0000);
    tick();
    check("post_rst_grant", bus.VALID_DREG, 4'b0100);
    bus.DREQ = 4'b0000; bus.HLDA = 1'b1;
    tick();
    bus.svcDone = 1'b1; bus.EOP_N = 1'b0;
    tick();
    bus.svcDone = 1'b0; bus.EOP_N = 1'b1;
    check("both_hrq", {3'b000, bus.HRQ}, 4'b0000);
    tick();
    check("both_dack", bus.DACK, 4'b1111);
    bus.HLDA = 1'b0;
    ticks(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
